// File: rtl/l1_dcache_pkg.sv
// Shared constants, types and helpers for the direct-mapped write-through L1 data cache.
package l1_dcache_pkg;

  localparam int unsigned LINE_BITS     = 512;
  localparam int unsigned WORD_BITS     = 64;
  localparam int unsigned OFFSET_BITS   = 6;
  localparam int unsigned WORD_SEL_LSB  = 3;
  localparam int unsigned WORD_SEL_BITS = OFFSET_BITS - WORD_SEL_LSB;

  typedef logic [LINE_BITS-1:0]     line_t;
  typedef logic [WORD_BITS-1:0]     word_t;
  typedef logic [WORD_SEL_BITS-1:0] word_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_RESP,
    MISS_REQ,
    WR_REQ,
    WR_WAIT
  } state_e;

  function automatic word_t line_word(input line_t line, input word_sel_t sel);
    return line[sel*WORD_BITS +: WORD_BITS];
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// Memory-stage and L2-side handshake bundle; slave is the cache, master is the environment.
interface l1_dcache_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BITS  = 512
);
  logic [ADDR_WIDTH-1:0] S_R_ADDR;
  logic                  S_R_ADDR_VALID;
  logic [DATA_WIDTH-1:0] S_R_DATA;
  logic                  S_R_DATA_VALID;
  logic                  S_W_VALID;
  logic [ADDR_WIDTH-1:0] S_W_ADDR;
  logic [DATA_WIDTH-1:0] S_W_DATA;
  logic                  S_W_READY;
  logic                  S_W_COMPLETE;
  logic [ADDR_WIDTH-1:0] L2_S_R_ADDR;
  logic                  L2_S_R_ADDR_VALID;
  logic [LINE_BITS-1:0]  L2_S_R_DATA;
  logic                  L2_S_R_DATA_VALID;
  logic                  L2_S_W_VALID;
  logic [ADDR_WIDTH-1:0] L2_S_W_ADDR;
  logic [DATA_WIDTH-1:0] L2_S_W_DATA;
  logic                  L2_S_W_READY;
  logic                  L2_S_W_COMPLETE;

  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA,
           L2_S_R_DATA, L2_S_R_DATA_VALID, L2_S_W_READY, L2_S_W_COMPLETE,
    output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE,
           L2_S_R_ADDR, L2_S_R_ADDR_VALID, L2_S_W_VALID, L2_S_W_ADDR, L2_S_W_DATA
  );

  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA,
           L2_S_R_DATA, L2_S_R_DATA_VALID, L2_S_W_READY, L2_S_W_COMPLETE,
    input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE,
           L2_S_R_ADDR, L2_S_R_ADDR_VALID, L2_S_W_VALID, L2_S_W_ADDR, L2_S_W_DATA
  );
endinterface

// File: rtl/l1_dcache_array.sv
// Tag/valid/data storage: asynchronous read port, one write port for full-line fills or single-word updates.
module l1_dcache_array
  import l1_dcache_pkg::*;
#(
  parameter  int NUM_SETS = 64,
  parameter  int TAG_BITS = 52,
  localparam int IDX_BITS = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output line_t               rd_line_o,
  input  logic                line_we_i,
  input  logic                word_we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  line_t               wr_line_i,
  input  word_sel_t           wr_sel_i,
  input  word_t               wr_word_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (line_we_i) valid_q[wr_idx_i] <= 1'b1;
  end

  // NOTE: tag/data are deliberately not reset; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][wr_sel_i*WORD_BITS +: WORD_BITS] <= wr_word_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache; one operation in flight at a time.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int ADDR_WIDTH = 64
) (
  input logic        clk,
  input logic        reset,
  l1_dcache_if.slave bus
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_LSB  = OFFSET_BITS + IDX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - TAG_LSB;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  word_t                 wdata_q;
  word_t                 s_r_data_q;
  logic                  s_r_data_valid_q;
  logic                  s_w_complete_q;
  logic                  l2_r_addr_valid_q;
  logic                  l2_w_valid_q;

  logic [IDX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0] lookup_tag;
  logic                arr_valid;
  logic [TAG_BITS-1:0] arr_tag;
  line_t               arr_line;
  logic                hit;
  logic                line_we;
  logic                word_we;

  // In IDLE the lookup follows the incoming read; afterwards it follows the captured operation.
  assign lookup_idx = (state_q == IDLE) ? bus.S_R_ADDR[TAG_LSB-1:OFFSET_BITS]
                                        : addr_q[TAG_LSB-1:OFFSET_BITS];
  assign lookup_tag = (state_q == IDLE) ? bus.S_R_ADDR[ADDR_WIDTH-1:TAG_LSB]
                                        : addr_q[ADDR_WIDTH-1:TAG_LSB];
  assign hit        = arr_valid && (arr_tag == lookup_tag);

  assign line_we = !reset && (state_q == MISS_REQ) && bus.L2_S_R_DATA_VALID;
  assign word_we = !reset && (state_q == WR_REQ) && bus.L2_S_W_READY && hit;

  l1_dcache_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (lookup_idx),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_line_o  (arr_line),
    .line_we_i  (line_we),
    .word_we_i  (word_we),
    .wr_idx_i   (addr_q[TAG_LSB-1:OFFSET_BITS]),
    .wr_tag_i   (addr_q[ADDR_WIDTH-1:TAG_LSB]),
    .wr_line_i  (bus.L2_S_R_DATA),
    .wr_sel_i   (addr_q[OFFSET_BITS-1:WORD_SEL_LSB]),
    .wr_word_i  (wdata_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      s_r_data_q        <= '0;
      s_r_data_valid_q  <= 1'b0;
      s_w_complete_q    <= 1'b0;
      l2_r_addr_valid_q <= 1'b0;
      l2_w_valid_q      <= 1'b0;
    end else begin
      s_r_data_valid_q <= 1'b0;
      s_w_complete_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.S_R_ADDR_VALID) begin
            addr_q <= bus.S_R_ADDR;
            if (hit) begin
              s_r_data_q       <= line_word(arr_line, bus.S_R_ADDR[OFFSET_BITS-1:WORD_SEL_LSB]);
              s_r_data_valid_q <= 1'b1;
              state_q          <= RD_RESP;
            end else begin
              l2_r_addr_valid_q <= 1'b1;
              state_q           <= MISS_REQ;
            end
          end else if (bus.S_W_VALID) begin
            addr_q       <= bus.S_W_ADDR;
            wdata_q      <= bus.S_W_DATA;
            l2_w_valid_q <= 1'b1;
            state_q      <= WR_REQ;
          end
        end
        RD_RESP: state_q <= IDLE;
        MISS_REQ: begin
          if (bus.L2_S_R_DATA_VALID) begin
            l2_r_addr_valid_q <= 1'b0;
            s_r_data_q        <= line_word(bus.L2_S_R_DATA, addr_q[OFFSET_BITS-1:WORD_SEL_LSB]);
            s_r_data_valid_q  <= 1'b1;
            state_q           <= RD_RESP;
          end
        end
        WR_REQ: begin
          if (bus.L2_S_W_READY) begin
            l2_w_valid_q <= 1'b0;
            state_q      <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.L2_S_W_COMPLETE) begin
            s_w_complete_q <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write acceptance depends on the live read request, so it cannot be registered.
  assign bus.S_W_READY         = !reset && (state_q == IDLE) && !bus.S_R_ADDR_VALID;
  assign bus.S_R_DATA          = s_r_data_q;
  assign bus.S_R_DATA_VALID    = s_r_data_valid_q;
  assign bus.S_W_COMPLETE      = s_w_complete_q;
  assign bus.L2_S_R_ADDR       = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign bus.L2_S_R_ADDR_VALID = l2_r_addr_valid_q;
  assign bus.L2_S_W_VALID      = l2_w_valid_q;
  assign bus.L2_S_W_ADDR       = addr_q;
  assign bus.L2_S_W_DATA       = wdata_q;

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: directed reads/writes against a behavioural L2 responder.
module tb_l1_dcache;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_dcache_if bus ();

  l1_dcache #(
    .NUM_SETS   (64),
    .ADDR_WIDTH (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int fill_cnt    = 0;
  int l2_wc_cnt   = 0;

  logic [63:0]  exp_rd_q   [$];
  logic [63:0]  exp_fill_q [$];
  logic [127:0] exp_l2w_q  [$];
  logic [63:0]  l2_mem [logic [63:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lines never written read back as {0xDEADBEEF ^ line_addr ^ 0x1000, word index}.
  function automatic logic [63:0] l2_word(input logic [63:0] line_addr, input int i);
    logic [63:0] wa;
    wa = line_addr + 64'(i * 8);
    if (l2_mem.exists(wa)) return l2_mem[wa];
    return {32'hDEADBEEF ^ line_addr[31:0] ^ 32'h0000_1000, 32'(i)};
  endfunction

  // Read-data monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.S_R_DATA_VALID === 1'b1) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected_pulse", 64'(bus.S_R_DATA_VALID), 64'd0);
        else check("rd_data", bus.S_R_DATA, exp_rd_q.pop_front());
      end
    end
  end

  // L2 fill responder
  initial begin
    logic [63:0] la;
    bus.L2_S_R_DATA       = '0;
    bus.L2_S_R_DATA_VALID = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.L2_S_R_ADDR_VALID === 1'b1 && reset === 1'b0) begin
        fill_cnt++;
        if (exp_fill_q.size() == 0) check("fill_unexpected", 64'(bus.L2_S_R_ADDR_VALID), 64'd0);
        else check("fill_addr", bus.L2_S_R_ADDR, exp_fill_q.pop_front());
        la = bus.L2_S_R_ADDR;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) bus.L2_S_R_DATA[i*64 +: 64] = l2_word(la, i);
        bus.L2_S_R_DATA_VALID = 1'b1;
        @(posedge clk);
        #1 bus.L2_S_R_DATA_VALID = 1'b0;
      end
    end
  end

  // L2 write-through responder
  initial begin
    logic [127:0] e;
    bus.L2_S_W_READY    = 1'b0;
    bus.L2_S_W_COMPLETE = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.L2_S_W_VALID === 1'b1 && reset === 1'b0) begin
        if (exp_l2w_q.size() == 0) check("l2w_unexpected", 64'(bus.L2_S_W_VALID), 64'd0);
        else begin
          e = exp_l2w_q.pop_front();
          check("l2w_addr", bus.L2_S_W_ADDR, e[127:64]);
          check("l2w_data", bus.L2_S_W_DATA, e[63:0]);
        end
        l2_mem[bus.L2_S_W_ADDR] = bus.L2_S_W_DATA;
        @(posedge clk);
        #1 bus.L2_S_W_READY = 1'b1;
        @(posedge clk);
        #1 bus.L2_S_W_READY = 1'b0;
        @(posedge clk);
        #1 bus.L2_S_W_COMPLETE = 1'b1;
        l2_wc_cnt++;
        @(posedge clk);
        #1 bus.L2_S_W_COMPLETE = 1'b0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({bus.S_R_DATA_VALID, bus.S_W_READY, bus.S_W_COMPLETE,
                               bus.L2_S_R_ADDR_VALID, bus.L2_S_W_VALID}), 64'd0);
    check({tag, "_s_r_data"}, bus.S_R_DATA, 64'd0);
    check({tag, "_l2_r_addr"}, bus.L2_S_R_ADDR, 64'd0);
    check({tag, "_l2_w_addr"}, bus.L2_S_W_ADDR, 64'd0);
    check({tag, "_l2_w_data"}, bus.L2_S_W_DATA, 64'd0);
  endtask

  // Called and returns at posedge+1; expects exactly exp_fills L2 fills during the read.
  task automatic do_read(input logic [63:0] a, input logic [63:0] exp, input int exp_fills);
    int f0, n;
    bit seen;
    f0 = fill_cnt;
    exp_rd_q.push_back(exp);
    if (exp_fills != 0) exp_fill_q.push_back({a[63:6], 6'b0});
    bus.S_R_ADDR       = a;
    bus.S_R_ADDR_VALID = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.S_R_DATA_VALID === 1'b1) seen = 1'b1;
    end
    check("rd_done", 64'(seen), 64'd1);
    @(posedge clk);
    #1 bus.S_R_ADDR_VALID = 1'b0;
    check("rd_fills", 64'(fill_cnt - f0), 64'(exp_fills));
    if (exp_fills == 0) check("hit_latency", 64'(n), 64'd2);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    int c0, n;
    bit ok;
    exp_l2w_q.push_back({a, d});
    c0 = l2_wc_cnt;
    bus.S_W_ADDR  = a;
    bus.S_W_DATA  = d;
    bus.S_W_VALID = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.S_W_READY === 1'b1) ok = 1'b1;
    end
    check("w_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 bus.S_W_VALID = 1'b0;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.S_W_COMPLETE === 1'b1) ok = 1'b1;
    end
    check("w_complete", 64'(ok), 64'd1);
    check("w_complete_after_l2", 64'(l2_wc_cnt - c0), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    reset              = 1'b1;
    bus.S_R_ADDR       = '0;
    bus.S_R_ADDR_VALID = 1'b0;
    bus.S_W_VALID      = 1'b0;
    bus.S_W_ADDR       = '0;
    bus.S_W_DATA       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("w_ready_idle", 64'(bus.S_W_READY), 64'd1);
    @(posedge clk);
    #1;

    // Cold miss, hits, write hit then read-back
    do_read(64'h1008, 64'hDEADBEEF_00000001, 1);
    do_read(64'h1008, 64'hDEADBEEF_00000001, 0);
    do_read(64'h1010, 64'hDEADBEEF_00000002, 0);
    do_write(64'h1010, 64'h11223344_55667788);
    do_read(64'h1010, 64'h11223344_55667788, 0);
    do_read(64'h1008, 64'hDEADBEEF_00000001, 0);

    // Conflict eviction in set 0
    do_read(64'h2000, 64'hDEAD8EEF_00000000, 1);
    do_read(64'h1008, 64'hDEADBEEF_00000001, 1);
    do_read(64'h1010, 64'h11223344_55667788, 0);

    // Write miss: forwarded, not allocated, set 0 untouched
    do_write(64'h8000, 64'hCAFEF00D_12345678);
    do_read(64'h1008, 64'hDEADBEEF_00000001, 0);
    do_read(64'h8000, 64'hCAFEF00D_12345678, 1);

    // Simultaneous read and write: read first, write held off
    exp_rd_q.push_back(64'hDEAD2EEF_00000001);
    bus.S_R_ADDR       = 64'h8008;
    bus.S_R_ADDR_VALID = 1'b1;
    bus.S_W_ADDR       = 64'h8008;
    bus.S_W_DATA       = 64'h01020304_05060708;
    bus.S_W_VALID      = 1'b1;
    @(negedge clk);
    check("w_ready_during_read", 64'(bus.S_W_READY), 64'd0);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      if (bus.S_R_DATA_VALID === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("simul_read_done", 64'(ok), 64'd1);
    check("simul_write_not_started", 64'(bus.L2_S_W_VALID), 64'd0);
    @(posedge clk);
    #1 bus.S_R_ADDR_VALID = 1'b0;
    do_write(64'h8008, 64'h01020304_05060708);
    do_read(64'h8008, 64'h01020304_05060708, 0);

    // Reset in the middle of a miss
    exp_fill_q.push_back(64'h4040);
    bus.S_R_ADDR       = 64'h4040;
    bus.S_R_ADDR_VALID = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.L2_S_R_ADDR_VALID === 1'b1) ok = 1'b1;
    end
    check("miss_req_seen", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    reset              = 1'b1;
    bus.S_R_ADDR_VALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("mid_miss_reset");
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_read(64'h4040, 64'hDEADEEAF_00000000, 1);
    do_read(64'h1008, 64'hDEADBEEF_00000001, 1);

    repeat (5) @(posedge clk);
    #1;
    check("rd_queue_left", 64'(exp_rd_q.size()), 64'd0);
    check("fill_queue_left", 64'(exp_fill_q.size()), 64'd0);
    check("l2w_queue_left", 64'(exp_l2w_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the pipeline memory stage and the shared last-level cache.
- Serves 64-bit doubleword reads and writes from the memory stage.
- Fetches 512-bit lines from L2 on a read miss.
- Forwards every write to L2 as a 64-bit word.
- Handles one outstanding operation at a time.

Parameters:
- NUM_SETS, 64, number of lines (power of 2); index = addr[6+log2(NUM_SETS)-1:6].
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, CPU data width.
- LINE_BITS, 512, line size (64 B); offset = addr[5:0], word select = addr[5:3].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- S_R_ADDR  in  64  CPU read address
- S_R_ADDR_VALID  in  1  read request; held high with a stable address until S_R_DATA_VALID
- S_R_DATA  out  64  aligned doubleword containing S_R_ADDR
- S_R_DATA_VALID  out  1  one-cycle pulse, read data valid
- S_W_VALID  in  1  write request
- S_W_ADDR  in  64  write address (8-byte aligned)
- S_W_DATA  in  64  write data
- S_W_READY  out  1  cache can accept a write this cycle
- S_W_COMPLETE  out  1  one-cycle pulse, write retired to L2
- L2_S_R_ADDR  out  64  line-aligned fill address (addr[5:0]=0)
- L2_S_R_ADDR_VALID  out  1  fill request; held until L2_S_R_DATA_VALID
- L2_S_R_DATA  in  512  fill line; byte 0 in bits [7:0]
- L2_S_R_DATA_VALID  in  1  fill data valid
- L2_S_W_VALID  out  1  write-through request
- L2_S_W_ADDR  out  64  write-through address
- L2_S_W_DATA  out  64  write-through data
- L2_S_W_READY  in  1  L2 accepts the write
- L2_S_W_COMPLETE  in  1  L2 write done

Behaviour:
- Reset:
  - All valid bits are cleared and the FSM goes to IDLE.
  - All outputs are 0, including S_W_READY.
  - Reset mid-operation aborts the operation; no completion pulse follows.
- States: IDLE, RD_RESP, MISS_REQ, WR_REQ, WR_WAIT.
- IDLE:
  - S_W_READY = 1 only when in IDLE and S_R_ADDR_VALID = 0.
  - Reads have priority over writes when both are requested in the same cycle.
  - On S_R_ADDR_VALID, capture the address.
    - Hit (valid and tag match) -> RD_RESP.
    - Miss -> MISS_REQ.
  - On S_W_VALID && S_W_READY, capture address and data -> WR_REQ.
- RD_RESP:
  - Drive S_R_DATA = line[addr[5:3]*64 +: 64] and S_R_DATA_VALID = 1 for exactly one cycle -> IDLE.
  - Hit latency: request seen in cycle N, data valid in cycle N+1.
  - Before accepting a new read, S_R_ADDR_VALID must be low or the address must have changed. The requester is responsible for this.
- MISS_REQ:
  - Drive L2_S_R_ADDR = {addr[63:6], 6'b0} and L2_S_R_ADDR_VALID = 1.
  - On L2_S_R_DATA_VALID: write the line, set tag and valid, drop the request -> RD_RESP, which returns the word from the fill data.
  - An outgoing read request must be held across arbitration stalls in the surrounding L2 mux.
- WR_REQ:
  - Drive L2_S_W_VALID with the captured address and data.
  - On L2_S_W_READY, drop valid -> WR_WAIT.
  - On a hit, update the cached doubleword at addr[5:3] in this state.
  - On a miss, do not allocate.
- WR_WAIT: on L2_S_W_COMPLETE, pulse S_W_COMPLETE for one cycle -> IDLE.
- Writes are full aligned doublewords. Sub-word stores are read-modify-write by the requester.
- Line replacement never writes back, because the cache is write-through.
- A line filled while a write to the same line is pending cannot occur, because operations are serialized.

Decomposition:
- Shared package: line size, offset/index/tag bit-field constants, and the state enum.
- One natural sub-module, l1_dcache_array: tag, valid and data storage with a read port and a line-write/word-write port.

Test Plan:
- Cold read, addr 0x1008; L2 returns a line with word1 = 0xDEADBEEF_00000001:
  - L2_S_R_ADDR = 0x1000.
  - S_R_DATA = 0xDEADBEEF00000001, pulsed once.
- Re-read 0x1008 after the fill -> no L2 request; data valid the next cycle.
- Conflict: read 0x1000 + NUM_SETS*64 -> new fill; a subsequent 0x1008 read misses again.
- Write 0x1010 = 0x1122334455667788 on a cached line:
  - L2_S_W_ADDR = 0x1010 and L2_S_W_DATA match the write.
  - S_W_COMPLETE pulses after L2_S_W_COMPLETE.
  - A read of 0x1010 hits and returns 0x1122334455667788.
- Write miss to 0x8000 -> forwarded to L2; a later read of 0x8000 issues an L2 fill (no allocate).
- Simultaneous read and write valid -> read serviced first with S_W_READY = 0.
  - Reset asserted mid-miss -> all outputs 0; the next read of the same address misses.
